// File: rtl/param_vec_serializer_pkg.sv
// vec_ser_pkg: shared state type and counter-width helper for the vector serializer
package vec_ser_pkg;

    typedef enum logic {IDLE, SHIFT} sv_state_t;

    function automatic int cw_f(int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/param_vec_serializer_if.sv
// param_vec_serializer_if: parallel-in / serial-out / frame-status bundle
interface param_vec_serializer_if #(
    parameter int WIDTH = 15,
    parameter int CW    = vec_ser_pkg::cw_f(WIDTH)
);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             ser_valid;
    logic             ser_bit;
    logic             ser_last;
    logic             ser_ready;
    logic             done_valid;
    logic [CW-1:0]    ones_count;
    logic             all_ones;

    modport master (
        output in_valid, in_data, ser_ready,
        input  in_ready, ser_valid, ser_bit, ser_last, done_valid, ones_count, all_ones
    );

    modport slave (
        input  in_valid, in_data, ser_ready,
        output in_ready, ser_valid, ser_bit, ser_last, done_valid, ones_count, all_ones
    );

endinterface

// File: rtl/param_vec_serializer.sv
// param_vec_serializer: streams a WIDTH-bit vector one bit per beat and reports its popcount
module param_vec_serializer
    import vec_ser_pkg::*;
#(
    parameter int WIDTH     = 15,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                   clk,
    input logic                   rst_n,
    param_vec_serializer_if.slave bus
);

    localparam int CW = cw_f(WIDTH);

    sv_state_t        state, state_nxt;
    logic             armed;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bitcnt;
    logic [CW-1:0]    popacc;
    logic [CW-1:0]    pop_sum;
    logic             last;
    logic             in_hs;
    logic             ser_hs;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; in_ready also opens on the final beat so frames chain without a bubble
    always_comb begin
        state_nxt     = state;
        last          = (state == SHIFT) && (bitcnt == CW'(WIDTH - 1));
        bus.ser_valid = (state == SHIFT);
        bus.ser_bit   = (state == SHIFT) && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
        bus.ser_last  = last;
        ser_hs        = bus.ser_valid && bus.ser_ready;
        bus.in_ready  = armed && ((state == IDLE) || (ser_hs && last));
        in_hs         = bus.in_valid && bus.in_ready;
        pop_sum       = popacc + CW'(bus.ser_bit);
        if (ser_hs && last) state_nxt = IDLE;
        if (in_hs)          state_nxt = SHIFT;
    end

    // Shift register and beat/popcount counters; armed keeps in_ready low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed  <= 1'b0;
            shreg  <= '0;
            bitcnt <= '0;
            popacc <= '0;
        end else begin
            armed <= 1'b1;
            if (in_hs) begin
                shreg  <= bus.in_data;
                bitcnt <= '0;
                popacc <= '0;
            end else if (ser_hs) begin
                shreg  <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                bitcnt <= bitcnt + CW'(1);
                popacc <= pop_sum;
            end
        end
    end

    // Frame status: one-cycle done pulse, count and all-ones flag held until the next frame completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.done_valid <= 1'b0;
            bus.ones_count <= '0;
            bus.all_ones   <= 1'b0;
        end else begin
            bus.done_valid <= ser_hs && last;
            if (ser_hs && last) begin
                bus.ones_count <= pop_sum;
                bus.all_ones   <= (pop_sum == CW'(WIDTH));
            end
        end
    end

endmodule
